// File: rtl/mux_behave_param_nx1_rr.sv
// ---------------------------------------------------------------------------
// mux_behave_param_nx1_rr
//   Registered N:1 word multiplexer with a one-entry valid/ready output stage.
//   mode=0 selects the channel given by in_selec. mode=1 schedules the valid
//   channels round-robin, starting from an internal pointer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_data    packed channel words, channel k = in_data[k*WIDTH +: WIDTH]
//   in_valid   per-channel word valid
//   in_ready   per-channel accept (one-hot or zero)
//   mode       0 = fixed select, 1 = round-robin
//   in_selec   channel index used when mode=0
//   out_y      registered selected word
//   out_chan   index of the channel held in out_y
//   out_valid  out_y/out_chan hold a word
//   out_ready  downstream accepts the held word
// ---------------------------------------------------------------------------
module mux_behave_param_nx1_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          in_selec,
  output logic [WIDTH-1:0]          out_y,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Channel count and last index expressed in select-sized vectors so all
  // index arithmetic stays width-matched.
  localparam logic [SEL_W:0]   CH_L    = CHANNELS[SEL_W:0];
  localparam int               CH_M1_I = CHANNELS - 1;
  localparam logic [SEL_W-1:0] CH_M1   = CH_M1_I[SEL_W-1:0];

  logic [WIDTH-1:0] r_out_y;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [WIDTH-1:0] w_ch     [CHANNELS];
  logic [SEL_W-1:0] w_cand   [CHANNELS];
  logic [CHANNELS-1:0] w_cand_v;

  logic             w_can_take;
  logic             w_grant_ok;
  logic [SEL_W-1:0] w_grant;
  logic             w_xfer;
  logic [CHANNELS-1:0] w_in_ready;

  // Unpack the channel words.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign w_ch[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin candidate for scan position gi: channel (rr_ptr + gi) mod N.
  // rr_ptr < N, so a single conditional subtract performs the wrap.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_scan
    localparam int             OFF_I = gi;
    localparam logic [SEL_W:0] OFF   = OFF_I[SEL_W:0];
    logic [SEL_W:0] w_sum;
    logic [SEL_W:0] w_wrap;
    assign w_sum       = {1'b0, r_rr_ptr} + OFF;
    assign w_wrap      = w_sum - CH_L;
    assign w_cand[gi]  = (w_sum >= CH_L) ? w_wrap[SEL_W-1:0] : w_sum[SEL_W-1:0];
    assign w_cand_v[gi] = in_valid[w_cand[gi]];
  end

  // Output stage can accept a new word when empty or draining this cycle.
  assign w_can_take = !r_out_valid || out_ready;

  always_comb begin
    w_grant_ok = 1'b0;
    w_grant    = '0;
    if (!mode) begin
      // Fixed select: grant does not look at in_valid; out-of-range means none.
      if ({1'b0, in_selec} < CH_L) begin
        w_grant_ok = 1'b1;
        w_grant    = in_selec;
      end
    end else begin
      // Walk from the farthest scan position back to position 0 so the
      // nearest valid channel after rr_ptr wins.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (w_cand_v[i]) begin
          w_grant_ok = 1'b1;
          w_grant    = w_cand[i];
        end
      end
    end
  end

  always_comb begin
    w_in_ready = '0;
    if (!rst && w_grant_ok) begin
      w_in_ready[w_grant] = w_can_take;
    end
  end

  assign in_ready = w_in_ready;
  assign w_xfer   = !rst && w_grant_ok && w_can_take && in_valid[w_grant];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_y     <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_xfer) begin
        // A transfer also covers the simultaneous-drain case: the new word
        // simply replaces the departing one.
        r_out_y     <= w_ch[w_grant];
        r_out_chan  <= w_grant;
        r_out_valid <= 1'b1;
        if (mode) begin
          r_rr_ptr <= (w_grant == CH_M1) ? '0 : w_grant + 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_y     = r_out_y;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule
